// File: rtl/pulse_pkg.sv
// pulse_pkg: shared constants and helpers for the pulse_stretcher slice.
//   - FSM state encoding (ST_IDLE / ST_HIGH / ST_GAP) and the matching enum
//   - default timing for the 200 Hz button/LED clock domain
//   - clog2 helper, usable in constant expressions
package pulse_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_HIGH = ST_HIGH,
    S_GAP  = ST_GAP
  } state_t;

  // 20 cycles at 200 Hz = 100 ms
  localparam int DEF_HIGH_CYC = 20;
  localparam int DEF_GAP_CYC  = 20;
  localparam int DEF_MAX_PEND = 7;

  // Ceiling log2; returns 0 for inputs <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// pulse_stretcher_if: event/LED signal bundle for pulse_stretcher.
//   pulse_in  - event input (per-cycle level, or raw async level in edge mode)
//   clr_ovf   - synchronous clear of the sticky overflow flag
//   led_out   - registered stretched flash
//   busy      - registered, high whenever the FSM is not idle
//   pend_cnt  - queued events not yet flashed
//   overflow  - sticky, an event was dropped
// modport master: the event source / observer side
// modport slave : the pulse_stretcher side
interface pulse_stretcher_if
  import pulse_pkg::*;
#(
  parameter int MAX_PEND = DEF_MAX_PEND
);

  logic                            pulse_in;
  logic                            clr_ovf;
  logic                            led_out;
  logic                            busy;
  logic [$clog2(MAX_PEND+1)-1:0]   pend_cnt;
  logic                            overflow;

  modport master (
    output pulse_in,
    output clr_ovf,
    input  led_out,
    input  busy,
    input  pend_cnt,
    input  overflow
  );

  modport slave (
    input  pulse_in,
    input  clr_ovf,
    output led_out,
    output busy,
    output pend_cnt,
    output overflow
  );

endinterface

// File: rtl/pulse_sync_edge.sv
// pulse_sync_edge: 2-FF synchronizer followed by a rising-edge detector.
//   clk_200H  - clock
//   rst_n     - async active-low reset, all flops reset to 0
//   async_in  - raw asynchronous level
//   rise_out  - one-cycle pulse on each synchronized 0->1 transition
// A held-high input produces exactly one rise_out pulse.
module pulse_sync_edge (
  input  logic clk_200H,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk_200H or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_out = sync_q & ~prev_q;

endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle button events into visible LED flashes.
// Each accepted event gives HIGH_CYC cycles of led_out=1 followed by GAP_CYC
// cycles off. Events arriving while a flash is in progress are queued in a
// saturating counter (up to MAX_PEND) and replayed back-to-back; events that
// find the queue full are dropped and set the sticky overflow flag.
//   clk_200H - 200 Hz button/LED clock
//   rst_n    - async active-low reset
//   bus      - pulse_stretcher_if.slave (pulse_in, clr_ovf in; led_out,
//              busy, pend_cnt, overflow out, all outputs registered)
// Build option PULSE_STRETCH_EDGE_IN_EN: pulse_in is a raw async level,
// synchronized and rising-edge detected (adds 2 cycles of latency).
// Without it, every high cycle of pulse_in is one event.
//
// state  | meaning
// IDLE   | no flash, queue empty, waiting for an event
// HIGH   | led on, timer counting down HIGH_CYC cycles
// GAP    | led off, timer counting down GAP_CYC cycles, then replay or idle
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int HIGH_CYC = DEF_HIGH_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC,
  parameter int MAX_PEND = DEF_MAX_PEND
) (
  input  logic               clk_200H,
  input  logic               rst_n,
  pulse_stretcher_if.slave   bus
);

  localparam int T_MAX = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
  localparam int TW    = (clog2(T_MAX) < 1) ? 1 : clog2(T_MAX);
  localparam int PW    = $clog2(MAX_PEND + 1);

  localparam logic [TW-1:0] T_HIGH_LD = TW'(HIGH_CYC - 1);
  localparam logic [TW-1:0] T_GAP_LD  = TW'(GAP_CYC - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PEND);

  logic ev;

`ifdef PULSE_STRETCH_EDGE_IN_EN
  pulse_sync_edge u_sync_edge (
    .clk_200H (clk_200H),
    .rst_n    (rst_n),
    .async_in (bus.pulse_in),
    .rise_out (ev)
  );
`else
  assign ev = bus.pulse_in;
`endif

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [PW-1:0]   pend_q,  pend_d;
  logic            ovf_q,   ovf_d;
  logic            led_q,   led_d;
  logic            busy_q,  busy_d;

  logic take;   // event consumed directly, never enters the queue
  logic pop;    // queued event replayed on GAP -> HIGH
  logic push;
  logic drop;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    take    = 1'b0;
    pop     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ev) begin
          state_d = S_HIGH;
          timer_d = T_HIGH_LD;
          take    = 1'b1;
        end
      end
      S_HIGH: begin
        if (timer_q == '0) begin
          state_d = S_GAP;
          timer_d = T_GAP_LD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_GAP: begin
        if (timer_q == '0) begin
          // queued events have priority over a fresh one so order is kept
          if (pend_q != '0) begin
            state_d = S_HIGH;
            timer_d = T_HIGH_LD;
            pop     = 1'b1;
          end else if (ev) begin
            state_d = S_HIGH;
            timer_d = T_HIGH_LD;
            take    = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    // A push that coincides with a pop leaves the count unchanged, so it
    // can never be dropped even when the queue is full.
    push = ev & ~take;
    drop = push & ~pop & (pend_q == PEND_MAX);

    pend_d = pend_q;
    if (push && !pop && !drop) begin
      pend_d = pend_q + PW'(1);
    end else if (pop && !push) begin
      pend_d = pend_q - PW'(1);
    end

    // drop is applied after clear so a same-cycle drop keeps the flag set
    ovf_d = ovf_q;
    if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end

    led_d  = (state_d == S_HIGH);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_200H or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.led_out  = led_q;
  assign bus.busy     = busy_q;
  assign bus.pend_cnt = pend_q;
  assign bus.overflow = ovf_q;

endmodule
